// File: rtl/core_pkg.sv
// Shared types and defaults for the core's instruction-sequencing logic.
package core_pkg;

    localparam int ADDR_WIDTH_DEFAULT = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        EXEC   = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    function automatic logic state_is_busy(input fetch_state_t st);
        return (st == FETCH) || (st == EXEC);
    endfunction

    function automatic logic state_accepts_start(input fetch_state_t st);
        return (st == IDLE) || (st == HALTED);
    endfunction

endpackage

// File: rtl/fetch_sequencer_inc_register.sv
// Loadable/incrementing register used as the program counter; load wins over increment.
module incRegister #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             wrEn,
    input  logic             incEn,
    input  logic [WIDTH-1:0] dataIn,
    output logic [WIDTH-1:0] dataOut
);

    logic [WIDTH-1:0] r_value;

    // Value register: load, increment (wrapping silently) or hold.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_value <= {WIDTH{1'b0}};
        end else if (wrEn) begin
            r_value <= dataIn;
        end else if (incEn) begin
            r_value <= r_value + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r_value <= r_value;
        end
    end

    assign dataOut = r_value;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer: drives the PC register and the instruction-memory handshake.
module fetch_sequencer
    import core_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] startAddr,
    input  logic                  memAck,
    input  logic                  execDone,
    input  logic                  jumpEn,
    input  logic [ADDR_WIDTH-1:0] jumpAddr,
    input  logic                  haltEn,
    input  logic                  stall,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic                  memReq,
    output logic                  irWrEn,
    output logic                  busy,
    output logic                  done
);

    fetch_state_t          r_state;
    fetch_state_t          w_next_state;
    logic                  w_pc_wr_en;
    logic                  w_pc_inc_en;
    logic                  w_ir_wr_en;
    logic [ADDR_WIDTH-1:0] w_pc_data_in;
    logic [ADDR_WIDTH-1:0] w_pc;

    // State register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and PC/IR enables; a stall suppresses every transition and enable.
    always_comb begin
        w_next_state = r_state;
        w_pc_wr_en   = 1'b0;
        w_pc_inc_en  = 1'b0;
        w_ir_wr_en   = 1'b0;
        w_pc_data_in = startAddr;
        if (stall) begin
            w_next_state = r_state;
        end else begin
            case (r_state)
                IDLE, HALTED: begin
                    if (start) begin
                        w_pc_wr_en   = 1'b1;
                        w_pc_data_in = startAddr;
                        w_next_state = FETCH;
                    end else begin
                        w_next_state = r_state;
                    end
                end
                FETCH: begin
                    if (memAck) begin
                        w_ir_wr_en   = 1'b1;
                        w_next_state = EXEC;
                    end else begin
                        w_next_state = FETCH;
                    end
                end
                EXEC: begin
                    if (!execDone) begin
                        w_next_state = EXEC;
                    end else if (haltEn) begin
                        w_next_state = HALTED;
                    end else if (jumpEn) begin
                        w_pc_wr_en   = 1'b1;
                        w_pc_data_in = jumpAddr;
                        w_next_state = FETCH;
                    end else begin
                        w_pc_inc_en  = 1'b1;
                        w_next_state = FETCH;
                    end
                end
                default: begin
                    w_next_state = IDLE;
                end
            endcase
        end
    end

    incRegister #(
        .WIDTH (ADDR_WIDTH)
    ) u_pc (
        .clk     (clk),
        .rstN    (rstN),
        .wrEn    (w_pc_wr_en),
        .incEn   (w_pc_inc_en),
        .dataIn  (w_pc_data_in),
        .dataOut (w_pc)
    );

    // Status outputs decode straight from the state register so they follow reset immediately.
    assign memAddr = w_pc;
    assign memReq  = (r_state == FETCH);
    assign irWrEn  = w_ir_wr_en;
    assign busy    = state_is_busy(r_state);
    assign done    = (r_state == HALTED);

endmodule
